// File: rtl/dram_bus_arbiter_pkg.sv
// Shared types for the IF/EX memory bus arbiter.
package dram_bus_arbiter_pkg;

    // Source tag stored for each accepted bus transaction
    localparam logic SRC_IRAM = 1'b0;
    localparam logic SRC_DRAM = 1'b1;

    // Grant FSM: IDLE arbitrates, HOLD_x locks the grant until the bus accepts
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } grant_state_e;

endpackage

// File: rtl/dram_bus_arbiter_tag_fifo.sv
// Small synchronous FIFO with an occupancy counter so that full and empty
// stay distinct when the pointers wrap onto each other.
module arb_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok, pop_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is refused even if a pop frees a slot this cycle
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage array, no reset needed: entries are only read when count says valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_bus_arbiter.sv
// Arbitrates fetch and data ports onto one SRAM-like bus and routes the
// in-order responses back to whichever port issued each transaction.
import dram_bus_arbiter_pkg::*;

module dram_bus_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              iram_req,
    input  logic [XLEN-1:0]   iram_addr,
    output logic              iram_addr_ok,
    output logic              iram_data_ok,
    output logic [XLEN-1:0]   iram_rdata,
    input  logic              dram_req,
    input  logic              dram_write,
    input  logic [XLEN/8-1:0] dram_wstrb,
    input  logic [XLEN-1:0]   dram_addr,
    input  logic [XLEN-1:0]   dram_wdata,
    output logic              dram_addr_ok,
    output logic              dram_data_ok,
    output logic [XLEN-1:0]   dram_rdata,
    output logic              bus_req,
    output logic              bus_write,
    output logic [XLEN/8-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [XLEN-1:0]   bus_rdata
);
    grant_state_e state_q, state_d;
    logic         grant_src;
    logic         granted_req;
    logic         fifo_full, fifo_empty;
    logic [0:0]   fifo_head;
    logic         push, pop;

    // Grant selection: data port wins in IDLE (older instruction), locked in HOLD
    always_comb begin
        grant_src = SRC_IRAM;
        case (state_q)
            HOLD_I:  grant_src = SRC_IRAM;
            HOLD_D:  grant_src = SRC_DRAM;
            default: grant_src = dram_req ? SRC_DRAM : SRC_IRAM;
        endcase
    end

    assign granted_req = (grant_src == SRC_DRAM) ? dram_req : iram_req;
    assign bus_req     = granted_req & ~fifo_full;
    assign bus_write   = (grant_src == SRC_DRAM) ? dram_write : 1'b0;
    assign bus_wstrb   = (grant_src == SRC_DRAM) ? dram_wstrb : '0;
    assign bus_addr    = (grant_src == SRC_DRAM) ? dram_addr  : iram_addr;
    assign bus_wdata   = (grant_src == SRC_DRAM) ? dram_wdata : '0;

    assign push         = bus_req & bus_addr_ok;
    assign pop          = bus_data_ok & ~fifo_empty;
    assign iram_addr_ok = push & (grant_src == SRC_IRAM);
    assign dram_addr_ok = push & (grant_src == SRC_DRAM);
    assign iram_data_ok = pop & (fifo_head[0] == SRC_IRAM);
    assign dram_data_ok = pop & (fifo_head[0] == SRC_DRAM);
    assign iram_rdata   = bus_rdata;
    assign dram_rdata   = bus_rdata;

    // Next grant state: lock onto a presented but unaccepted request
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus_req && !bus_addr_ok)
                    state_d = (grant_src == SRC_DRAM) ? HOLD_D : HOLD_I;
            end
            HOLD_I, HOLD_D: begin
                if (bus_addr_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant state register
    always_ff @(posedge clk) begin
        if (rst_b) state_q <= IDLE;
        else       state_q <= state_d;
    end

    arb_tag_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push),
        .din   (grant_src),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A response with nothing outstanding is a bus protocol violation; it is dropped
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            assert (!(bus_data_ok && fifo_empty))
                else $warning("bus_data_ok with no outstanding transaction, response dropped");
        end
    end

endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Directed bench for dram_bus_arbiter: a per-cycle vector table plus a
// hand-written reset-while-outstanding sequence.
module tb_dram_bus_arbiter;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        iram_req;
    logic [31:0] iram_addr;
    logic        iram_addr_ok, iram_data_ok;
    logic [31:0] iram_rdata;
    logic        dram_req, dram_write;
    logic [3:0]  dram_wstrb;
    logic [31:0] dram_addr, dram_wdata;
    logic        dram_addr_ok, dram_data_ok;
    logic [31:0] dram_rdata;
    logic        bus_req, bus_write;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    dram_bus_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_b(rst_b),
        .iram_req(iram_req), .iram_addr(iram_addr), .iram_addr_ok(iram_addr_ok),
        .iram_data_ok(iram_data_ok), .iram_rdata(iram_rdata),
        .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_addr_ok(dram_addr_ok),
        .dram_data_ok(dram_data_ok), .dram_rdata(dram_rdata),
        .bus_req(bus_req), .bus_write(bus_write), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    typedef struct packed {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [3:0]  dstrb;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        baok;
        logic        bdok;
        logic [31:0] brdata;
    } stim_t;

    // iaok, daok, idok, ddok, breq, bwrite, bwstrb, baddr, bwdata, irdata, drdata
    typedef struct packed {
        logic        iaok;
        logic        daok;
        logic        idok;
        logic        ddok;
        logic        breq;
        logic        bwr;
        logic [3:0]  bstrb;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } resp_t;

    typedef struct packed {
        stim_t s;
        resp_t e;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic stim_t st(logic ireq, logic [31:0] ia, logic dreq, logic dwr,
                                 logic [3:0] ds, logic [31:0] da, logic [31:0] dw,
                                 logic baok, logic bdok, logic [31:0] rd);
        stim_t s;
        s = '{ireq, ia, dreq, dwr, ds, da, dw, baok, bdok, rd};
        return s;
    endfunction

    function automatic resp_t ex(logic iaok, logic daok, logic idok, logic ddok,
                                 logic breq, logic bwr, logic [3:0] bs,
                                 logic [31:0] ba, logic [31:0] bw, logic [31:0] rd);
        resp_t r;
        r = '{iaok, daok, idok, ddok, breq, bwr, bs, ba, bw, rd, rd};
        return r;
    endfunction

    task automatic drive(input stim_t s);
        iram_req    = s.ireq;  iram_addr  = s.iaddr;
        dram_req    = s.dreq;  dram_write = s.dwr;
        dram_wstrb  = s.dstrb; dram_addr  = s.daddr; dram_wdata = s.dwdata;
        bus_addr_ok = s.baok;  bus_data_ok = s.bdok; bus_rdata = s.brdata;
    endtask

    function automatic resp_t sample();
        resp_t r;
        r = '{iram_addr_ok, dram_addr_ok, iram_data_ok, dram_data_ok, bus_req,
              bus_write, bus_wstrb, bus_addr, bus_wdata, iram_rdata, dram_rdata};
        return r;
    endfunction

    task automatic check(input string name, input resp_t exp);
        resp_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and check settled outputs
    task automatic step(input string name, input stim_t s, input resp_t e);
        @(negedge clk);
        drive(s);
        #1;
        check(name, e);
    endtask

    initial begin
        stim_t idle_s;
        idle_s = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle_s);
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;

        // 0: after reset, no requests
        vecs.push_back('{idle_s, ex(0,0,0,0, 0,0,4'h0, 32'h0, 0, 0)});
        // 1-4: simultaneous requests, dram first, then responses in order
        vecs.push_back('{st(1,32'h2000, 1,0,4'h0,32'h100,0, 1,0,0),
                         ex(0,1,0,0, 1,0,4'h0, 32'h100, 0, 0)});
        vecs.push_back('{st(1,32'h2000, 0,0,4'h0,0,0, 1,0,0),
                         ex(1,0,0,0, 1,0,4'h0, 32'h2000, 0, 0)});
        vecs.push_back('{st(0,0, 0,0,0,0,0, 0,1,32'h11),
                         ex(0,0,0,1, 0,0,4'h0, 32'h0, 0, 32'h11)});
        vecs.push_back('{st(0,0, 0,0,0,0,0, 0,1,32'h22),
                         ex(0,0,1,0, 0,0,4'h0, 32'h0, 0, 32'h22)});
        // 5-11: iram locked while bus stalls, dram arrives meanwhile
        vecs.push_back('{st(1,32'h3000, 0,0,0,0,0, 0,0,0),
                         ex(0,0,0,0, 1,0,4'h0, 32'h3000, 0, 0)});
        vecs.push_back('{st(1,32'h3000, 1,0,0,32'h400,0, 0,0,0),
                         ex(0,0,0,0, 1,0,4'h0, 32'h3000, 0, 0)});
        vecs.push_back('{st(1,32'h3000, 1,0,0,32'h400,0, 0,0,0),
                         ex(0,0,0,0, 1,0,4'h0, 32'h3000, 0, 0)});
        vecs.push_back('{st(1,32'h3000, 1,0,0,32'h400,0, 1,0,0),
                         ex(1,0,0,0, 1,0,4'h0, 32'h3000, 0, 0)});
        vecs.push_back('{st(0,0, 1,0,0,32'h400,0, 1,0,0),
                         ex(0,1,0,0, 1,0,4'h0, 32'h400, 0, 0)});
        vecs.push_back('{st(0,0, 0,0,0,0,0, 0,1,32'h33),
                         ex(0,0,1,0, 0,0,4'h0, 32'h0, 0, 32'h33)});
        vecs.push_back('{st(0,0, 0,0,0,0,0, 0,1,32'h44),
                         ex(0,0,0,1, 0,0,4'h0, 32'h0, 0, 32'h44)});
        // 12-13: store fields pass through unchanged
        vecs.push_back('{st(0,0, 1,1,4'b0100,32'h500,32'h00AB0000, 1,0,0),
                         ex(0,1,0,0, 1,1,4'b0100, 32'h500, 32'h00AB0000, 0)});
        vecs.push_back('{st(0,0, 0,0,0,0,0, 0,1,32'h55),
                         ex(0,0,0,1, 0,0,4'h0, 32'h0, 0, 32'h55)});
        // 14-20: FIFO full blocks the third request, even with a same-cycle pop
        vecs.push_back('{st(1,32'h600, 0,0,0,0,0, 1,0,0),
                         ex(1,0,0,0, 1,0,4'h0, 32'h600, 0, 0)});
        vecs.push_back('{st(1,32'h604, 0,0,0,0,0, 1,0,0),
                         ex(1,0,0,0, 1,0,4'h0, 32'h604, 0, 0)});
        vecs.push_back('{st(1,32'h608, 0,0,0,0,0, 1,0,0),
                         ex(0,0,0,0, 0,0,4'h0, 32'h608, 0, 0)});
        vecs.push_back('{st(1,32'h608, 0,0,0,0,0, 1,1,32'h66),
                         ex(0,0,1,0, 0,0,4'h0, 32'h608, 0, 32'h66)});
        vecs.push_back('{st(1,32'h608, 0,0,0,0,0, 1,0,0),
                         ex(1,0,0,0, 1,0,4'h0, 32'h608, 0, 0)});
        vecs.push_back('{st(0,0, 0,0,0,0,0, 0,1,32'h77),
                         ex(0,0,1,0, 0,0,4'h0, 32'h0, 0, 32'h77)});
        vecs.push_back('{st(0,0, 0,0,0,0,0, 0,1,32'h88),
                         ex(0,0,1,0, 0,0,4'h0, 32'h0, 0, 32'h88)});
        // 21: stray response with empty FIFO is dropped
        vecs.push_back('{st(0,0, 0,0,0,0,0, 0,1,32'h99),
                         ex(0,0,0,0, 0,0,4'h0, 32'h0, 0, 32'h99)});

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);

        // Reset with two transactions outstanding; late responses are dropped
        step("rst_acc0", st(0,0, 1,0,0,32'h700,0, 1,0,0),
             ex(0,1,0,0, 1,0,4'h0, 32'h700, 0, 0));
        step("rst_acc1", st(1,32'h800, 0,0,0,0,0, 1,0,0),
             ex(1,0,0,0, 1,0,4'h0, 32'h800, 0, 0));
        @(negedge clk);
        drive(idle_s);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        step("rst_idle", idle_s, ex(0,0,0,0, 0,0,4'h0, 32'h0, 0, 0));
        step("rst_drop0", st(0,0, 0,0,0,0,0, 0,1,32'hA1),
             ex(0,0,0,0, 0,0,4'h0, 32'h0, 0, 32'hA1));
        step("rst_drop1", st(0,0, 0,0,0,0,0, 0,1,32'hA2),
             ex(0,0,0,0, 0,0,4'h0, 32'h0, 0, 32'hA2));
        step("post_rst_req", st(1,32'h900, 0,0,0,0,0, 1,0,0),
             ex(1,0,0,0, 1,0,4'h0, 32'h900, 0, 0));
        step("post_rst_rsp", st(0,0, 0,0,0,0,0, 0,1,32'hB0),
             ex(0,0,1,0, 0,0,4'h0, 32'h0, 0, 32'hB0));

        @(negedge clk);
        drive(idle_s);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
